// File: rtl/ad7606_emulator.sv
// AD7606 responder model: decodes RESET/CONVST/CS/RD from a controller, drives BUSY for a
// programmable conversion time and serves a snapshot of eight generated channel words.
module ad7606_emulator #(
  parameter int P_CONV_CYCLES = 200,
  parameter int P_SYNC_EN     = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ad_reset,
  input  logic        i_ad_convstA,
  input  logic        i_ad_convstB,
  input  logic        i_ad_cs,
  input  logic        i_ad_rd,
  input  logic [2:0]  i_ad_osc,
  input  logic [1:0]  i_pattern_mode,
  input  logic [15:0] i_fixed_data,
  output logic        o_ad_busy,
  output logic        o_ad_firstdata,
  output logic [15:0] o_ad_data,
  output logic [15:0] o_conv_cnt,
  output logic        o_rd_err
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CONV  = 2'd2
  } state_t;

  // Input vector {osc[2:0], rd, cs, convstB, convstA, reset}. Strobes reset to their idle
  // level so releasing i_rst_n with CONVST already high does not fake a rising edge.
  localparam logic [7:0] LP_IN_IDLE = 8'b0001_1110;

  logic [7:0]  pins_s;
  logic [7:0]  in_s;
  logic [2:0]  prev_q, prev_d;

  logic        reset_s;
  logic        conv_rise_s;
  logic        cs_low_s;
  logic        rd_fall_s;
  logic [2:0]  osc_s;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [15:0] samp_q, samp_d;
  logic [15:0] snap_q [8];
  logic [15:0] snap_d [8];
  logic        busy_q, busy_d;
  logic        first_q, first_d;
  logic [15:0] data_q, data_d;
  logic [15:0] conv_cnt_q, conv_cnt_d;
  logic        rd_err_q, rd_err_d;

  function automatic logic [23:0] conv_len(input logic [2:0] osc);
    logic [23:0] base;
    base = 24'(P_CONV_CYCLES);
    case (osc)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6: conv_len = base << osc;
      default:                            conv_len = base;
    endcase
  endfunction

  function automatic logic [15:0] gen_word(input logic [1:0]  mode,
                                           input logic [2:0]  c,
                                           input logic [15:0] s,
                                           input logic [15:0] fixed);
    case (mode)
      2'd0:    gen_word = s + {1'b0, c, 12'd0};
      2'd1:    gen_word = fixed ^ {c, 13'd0};
      2'd2:    gen_word = 16'h1111 * ({13'd0, c} + 16'd1);
      2'd3:    gen_word = c[0] ? (16'd0 - s) : s;
      default: gen_word = 16'd0;
    endcase
  endfunction

  assign pins_s = {i_ad_osc, i_ad_rd, i_ad_cs, i_ad_convstB, i_ad_convstA, i_ad_reset};

  generate
    if (P_SYNC_EN != 0) begin : g_sync2
      logic [7:0] meta_q;
      logic [7:0] sync_q;
      // Two-stage synchronizer for a controller in another clock domain.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          meta_q <= LP_IN_IDLE;
          sync_q <= LP_IN_IDLE;
        end else begin
          meta_q <= pins_s;
          sync_q <= meta_q;
        end
      end
      assign in_s = sync_q;
    end else begin : g_sync1
      logic [7:0] sync_q;
      // Single input register for a controller on the same clock.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          sync_q <= LP_IN_IDLE;
        end else begin
          sync_q <= pins_s;
        end
      end
      assign in_s = sync_q;
    end
  endgenerate

  assign reset_s     = in_s[0];
  assign cs_low_s    = ~in_s[3];
  assign osc_s       = in_s[7:5];
  assign conv_rise_s = (in_s[1] & in_s[2]) & ~(prev_q[0] & prev_q[1]);
  assign rd_fall_s   = ~in_s[4] & prev_q[2];
  assign prev_d      = {in_s[4], in_s[2], in_s[1]};

  // Next-state, conversion timer, snapshot and read-port logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    samp_d     = samp_q;
    busy_d     = busy_q;
    first_d    = first_q;
    data_d     = data_q;
    conv_cnt_d = conv_cnt_q;
    rd_err_d   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      snap_d[i] = snap_q[i];
    end

    if (reset_s) begin
      state_d = ST_RESET;
      busy_d  = 1'b0;
      ptr_d   = 3'd0;
      cnt_d   = 24'd0;
      for (int i = 0; i < 8; i++) begin
        snap_d[i] = 16'd0;
      end
    end else begin
      case (state_q)
        ST_RESET: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        ST_IDLE: begin
          if (conv_rise_s) begin
            state_d = ST_CONV;
            busy_d  = 1'b1;
            cnt_d   = conv_len(osc_s) - 24'd1;
          end else begin
            busy_d  = 1'b0;
          end
          if (rd_fall_s && cs_low_s) begin
            data_d  = snap_q[ptr_q];
            first_d = (ptr_q == 3'd0);
            ptr_d   = ptr_q + 3'd1;
          end else begin
            data_d  = data_q;
          end
        end
        ST_CONV: begin
          if (cnt_q == 24'd0) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            ptr_d      = 3'd0;
            samp_d     = samp_q + 16'd1;
            conv_cnt_d = conv_cnt_q + 16'd1;
            for (int i = 0; i < 8; i++) begin
              snap_d[i] = gen_word(i_pattern_mode, 3'(i), samp_q, i_fixed_data);
            end
          end else begin
            cnt_d = cnt_q - 24'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end

    // A read strobe outside IDLE is flagged and otherwise ignored.
    if (rd_fall_s && cs_low_s && ((state_q == ST_CONV) || (state_q == ST_RESET))) begin
      rd_err_d = 1'b1;
    end else begin
      rd_err_d = 1'b0;
    end

    if (!cs_low_s) begin
      first_d = 1'b0;
    end else begin
      first_d = first_d;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_RESET;
      prev_q     <= 3'b111;
      cnt_q      <= 24'd0;
      ptr_q      <= 3'd0;
      samp_q     <= 16'd0;
      busy_q     <= 1'b0;
      first_q    <= 1'b0;
      data_q     <= 16'd0;
      conv_cnt_q <= 16'd0;
      rd_err_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        snap_q[i] <= 16'd0;
      end
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      samp_q     <= samp_d;
      busy_q     <= busy_d;
      first_q    <= first_d;
      data_q     <= data_d;
      conv_cnt_q <= conv_cnt_d;
      rd_err_q   <= rd_err_d;
      for (int i = 0; i < 8; i++) begin
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign o_ad_busy      = busy_q;
  assign o_ad_firstdata = first_q;
  assign o_ad_data      = data_q;
  assign o_conv_cnt     = conv_cnt_q;
  assign o_rd_err       = rd_err_q;

endmodule

// File: tb/tb_ad7606_emulator.sv
// Scoreboard bench for ad7606_emulator: conversions, reads, oversampling, retrigger,
// mid-conversion reset and illegal reads.
module tb_ad7606_emulator;

  logic        clk;
  logic        rst_n;
  logic        ad_reset;
  logic        conv_a;
  logic        conv_b;
  logic        cs;
  logic        rd;
  logic [2:0]  osc;
  logic [1:0]  mode;
  logic [15:0] fixed;
  logic        busy;
  logic        first;
  logic [15:0] data;
  logic [15:0] conv_cnt;
  logic        rd_err;

  int          n_checks;
  int          n_fail;
  logic [15:0] m_snap [8];
  logic [15:0] m_samp;
  logic [15:0] m_cnt;
  int          m_ptr;
  logic [15:0] last_data;
  logic [16:0] sb_q [$];
  int          len;

  ad7606_emulator #(.P_CONV_CYCLES(200), .P_SYNC_EN(0)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ad_reset    (ad_reset),
    .i_ad_convstA  (conv_a),
    .i_ad_convstB  (conv_b),
    .i_ad_cs       (cs),
    .i_ad_rd       (rd),
    .i_ad_osc      (osc),
    .i_pattern_mode(mode),
    .i_fixed_data  (fixed),
    .o_ad_busy     (busy),
    .o_ad_firstdata(first),
    .o_ad_data     (data),
    .o_conv_cnt    (conv_cnt),
    .o_rd_err      (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_word(input int md, input int c, input int s, input int fx);
    int v;
    case (md)
      0:       v = s + c * 4096;
      1:       v = fx ^ (c * 8192);
      2:       v = 4369 * (c + 1);
      3:       v = ((c % 2) == 0) ? s : -s;
      default: v = 0;
    endcase
    return v[15:0];
  endfunction

  task automatic model_conv();
    for (int c = 0; c < 8; c++) begin
      m_snap[c] = exp_word(int'(mode), c, int'(m_samp), int'(fixed));
    end
    m_samp = m_samp + 16'd1;
    m_cnt  = m_cnt + 16'd1;
    m_ptr  = 0;
  endtask

  task automatic do_read();
    logic [16:0] e;
    sb_q.push_back({(m_ptr == 0) ? 1'b1 : 1'b0, m_snap[m_ptr]});
    m_ptr = (m_ptr + 1) % 8;
    cs = 1'b0;
    rd = 1'b0;
    tick();
    rd = 1'b1;
    tick();
    e = sb_q.pop_front();
    check_val("rd_data", {16'd0, data}, {16'd0, e[15:0]});
    check_val("rd_first", {31'd0, first}, {31'd0, e[16]});
    last_data = e[15:0];
    cs = 1'b1;
    tick();
  endtask

  task automatic pulse_conv();
    conv_a = 1'b0;
    conv_b = 1'b0;
    tick();
    tick();
    conv_a = 1'b1;
    conv_b = 1'b1;
    tick();
    check_val("busy_early", {31'd0, busy}, 32'd0);
    tick();
    check_val("busy_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic measure(input int retrig_at, input int reset_at, output int n);
    n = 0;
    while (busy && n < 20000) begin
      n++;
      if (n == retrig_at) begin
        conv_a = 1'b0;
        conv_b = 1'b0;
      end
      if (n == retrig_at + 3) begin
        conv_a = 1'b1;
        conv_b = 1'b1;
      end
      if (n == reset_at) ad_reset = 1'b1;
      tick();
    end
    if (n >= 20000) check_val("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    m_samp = 16'd0; m_cnt = 16'd0; m_ptr = 0; last_data = 16'd0;
    for (int c = 0; c < 8; c++) m_snap[c] = 16'd0;
    rst_n = 1'b0; ad_reset = 1'b0; conv_a = 1'b1; conv_b = 1'b1;
    cs = 1'b1; rd = 1'b1; osc = 3'd0; mode = 2'd0; fixed = 16'd0;
    repeat (3) tick();
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_first", {31'd0, first}, 32'd0);
    check_val("rst_data", {16'd0, data}, 32'd0);
    check_val("rst_cnt", {16'd0, conv_cnt}, 32'd0);
    check_val("rst_err", {31'd0, rd_err}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_val("post_rst_busy", {31'd0, busy}, 32'd0);
    check_val("post_rst_cnt", {16'd0, conv_cnt}, 32'd0);
    ad_reset = 1'b1; tick(); tick();
    ad_reset = 1'b0; tick(); tick();

    // ramp pattern, two conversions
    for (int k = 0; k < 2; k++) begin
      pulse_conv();
      measure(-1, -1, len);
      check_val("busy_len_osc0", len, 32'd200);
      model_conv();
      check_val("conv_cnt", {16'd0, conv_cnt}, {16'd0, m_cnt});
      for (int r = 0; r < 8; r++) do_read();
    end
    tick();
    check_val("cs_high_first", {31'd0, first}, 32'd0);
    check_val("cs_high_hold", {16'd0, data}, {16'd0, last_data});

    // oversampling lengths
    osc = 3'd3;
    pulse_conv(); measure(-1, -1, len); model_conv();
    check_val("busy_len_osc3", len, 32'd1600);
    osc = 3'd7;
    pulse_conv(); measure(-1, -1, len); model_conv();
    check_val("busy_len_osc7", len, 32'd200);
    osc = 3'd0;

    // CONVST during conversion is ignored
    pulse_conv(); measure(50, -1, len); model_conv();
    check_val("busy_len_retrig", len, 32'd200);
    check_val("conv_cnt_retrig", {16'd0, conv_cnt}, {16'd0, m_cnt});

    // reset aborts a conversion
    pulse_conv(); measure(-1, 100, len);
    check_val("busy_len_abort", len, 32'd101);
    repeat (3) tick();
    ad_reset = 1'b0;
    repeat (3) tick();
    check_val("conv_cnt_abort", {16'd0, conv_cnt}, {16'd0, m_cnt});
    for (int c = 0; c < 8; c++) m_snap[c] = 16'd0;
    m_ptr = 0;
    do_read(); do_read();

    // illegal read during busy, then ID pattern with pointer wrap
    mode = 2'd2;
    pulse_conv();
    repeat (5) tick();
    cs = 1'b0; rd = 1'b0; tick();
    rd = 1'b1; tick();
    check_val("rd_err_pulse", {31'd0, rd_err}, 32'd1);
    check_val("rd_err_data", {16'd0, data}, {16'd0, last_data});
    tick();
    check_val("rd_err_clear", {31'd0, rd_err}, 32'd0);
    cs = 1'b1;
    measure(-1, -1, len); model_conv();
    check_val("conv_cnt_id", {16'd0, conv_cnt}, {16'd0, m_cnt});
    for (int r = 0; r < 9; r++) do_read();

    // fixed and sign patterns
    mode = 2'd1; fixed = 16'hA5C3;
    pulse_conv(); measure(-1, -1, len); model_conv();
    for (int r = 0; r < 8; r++) do_read();
    mode = 2'd3;
    pulse_conv(); measure(-1, -1, len); model_conv();
    for (int r = 0; r < 8; r++) do_read();
    check_val("conv_cnt_final", {16'd0, conv_cnt}, {16'd0, m_cnt});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
